// File: rtl/alu3_ctrl_pkg.sv
// Shared types and constants for the 3-bit ALU arbitration controller.
// Holds FSM states, op-code encodings, the settle counter width and the request bundle.
package alu3_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic       sub;
    } req_t;

    // Ops with OP1 clear use the adder path, so carry-in, B-invert and overflow apply.
    function automatic logic is_arith(input logic [1:0] op);
        return op[1] == OP_ADD[1];
    endfunction

endpackage

// File: rtl/alu3_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valid pair, pointer moves on advance.
// Zero latency; a lone valid always wins, a tie goes to the pointer, which then flips to the loser.
module alu3_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       idx
);

    logic ptr;

    always_comb begin
        idx = 1'b0;
        if (valid == 2'b11) begin
            idx = ptr;
        end else if (valid[1]) begin
            idx = 1'b1;
        end
        grant = 2'b00;
        if (valid != 2'b00) begin
            grant = idx ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~idx;
        end
    end

endmodule

// File: rtl/alu3_arb_ctrl.sv
// Arbitrates two requesters onto an external 3-bit ALU; response SETTLE_CYC+2 cycles after grant,
// held until rsp_ready, no new grant while in flight. ALU3_STICKY_OVF_EN adds sticky overflow + ovf_clr.
module alu3_arb_ctrl
    import alu3_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    input  logic       r1_valid,
    output logic       r0_ready,
    output logic       r1_ready,
    input  logic [1:0] r0_op,
    input  logic [1:0] r1_op,
    input  logic [2:0] r0_a,
    input  logic [2:0] r0_b,
    input  logic [2:0] r1_a,
    input  logic [2:0] r1_b,
    input  logic       r0_sub,
    input  logic       r1_sub,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_binv,
    output logic       alu_cin,
    output logic       alu_x,
    input  logic [2:0] alu_res,
    input  logic       alu_ovf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [2:0] rsp_res,
    output logic       rsp_ovf,
`ifdef ALU3_STICKY_OVF_EN
    input  logic       ovf_clr,
`endif
    output logic       status_ovf
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             gnt_idx;
    logic             gnt_id;
    logic             take;
    req_t             req_sel;

    alu3_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({r1_valid, r0_valid}),
        .advance (take),
        .grant   (grant),
        .idx     (gnt_idx)
    );

    // Reset also masks the handshake so ready reads 0 while rst is high.
    assign take     = (state == ST_IDLE) && (grant != 2'b00) && !rst;
    assign r0_ready = take & grant[0];
    assign r1_ready = take & grant[1];
    assign req_sel  = gnt_idx ? {r1_op, r1_a, r1_b, r1_sub} : {r0_op, r0_a, r0_b, r0_sub};
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (take) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (cnt == '0) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            alu_binv <= 1'b0;
            alu_cin  <= 1'b0;
            alu_x    <= 1'b0;
            gnt_id   <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_res  <= '0;
            rsp_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                alu_a    <= req_sel.a;
                alu_b    <= req_sel.b;
                alu_op   <= req_sel.op;
                alu_x    <= is_arith(req_sel.op);
                alu_binv <= req_sel.sub & is_arith(req_sel.op);
                alu_cin  <= req_sel.sub & is_arith(req_sel.op);
                gnt_id   <= gnt_idx;
                cnt      <= CNT_W'(SETTLE_CYC - 1);
            end else if (state == ST_SETTLE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == ST_CAPTURE) begin
                rsp_res <= alu_res;
                rsp_ovf <= alu_ovf & alu_x;
                rsp_id  <= gnt_id;
            end
        end
    end

`ifdef ALU3_STICKY_OVF_EN
    logic sticky_ovf;

    // Clear has priority over a same-cycle capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (ovf_clr) begin
            sticky_ovf <= 1'b0;
        end else if (state == ST_CAPTURE && alu_ovf && alu_x) begin
            sticky_ovf <= 1'b1;
        end
    end

    assign status_ovf = sticky_ovf;
`else
    assign status_ovf = rsp_ovf & rsp_valid;
`endif

endmodule

// File: tb/tb_alu3_arb_ctrl.sv
// Bench for alu3_arb_ctrl with a behavioural ALU and an integer-arithmetic reference model.
module tb_alu3_arb_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] vld = 2'b00;
    logic       r0_valid, r1_valid, r0_ready, r1_ready;
    logic [1:0] r0_op, r1_op;
    logic [2:0] r0_a, r0_b, r1_a, r1_b;
    logic       r0_sub, r1_sub;
    logic [2:0] alu_a, alu_b, alu_res, rsp_res;
    logic [1:0] alu_op;
    logic       alu_binv, alu_cin, alu_x, alu_ovf;
    logic       rsp_valid, rsp_id, rsp_ovf, status_ovf;
    logic       rsp_ready = 1'b0;
`ifdef ALU3_STICKY_OVF_EN
    logic       ovf_clr = 1'b0;
    bit         sticky_m = 1'b0;
`endif

    logic [1:0] req_op  [2];
    logic [2:0] req_a   [2];
    logic [2:0] req_b   [2];
    logic       req_sub [2];

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    assign r0_valid = vld[0];
    assign r1_valid = vld[1];
    assign r0_op = req_op[0];
    assign r1_op = req_op[1];
    assign r0_a = req_a[0];
    assign r1_a = req_a[1];
    assign r0_b = req_b[0];
    assign r1_b = req_b[1];
    assign r0_sub = req_sub[0];
    assign r1_sub = req_sub[1];

    always #5 clk = ~clk;

    alu3_arb_ctrl #(.SETTLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r1_valid   (r1_valid),
        .r0_ready   (r0_ready),
        .r1_ready   (r1_ready),
        .r0_op      (r0_op),
        .r1_op      (r1_op),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .r0_sub     (r0_sub),
        .r1_sub     (r1_sub),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_binv   (alu_binv),
        .alu_cin    (alu_cin),
        .alu_x      (alu_x),
        .alu_res    (alu_res),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_ovf    (rsp_ovf),
`ifdef ALU3_STICKY_OVF_EN
        .ovf_clr    (ovf_clr),
`endif
        .status_ovf (status_ovf)
    );

    // External ALU: adder path always computes overflow; the controller must gate it.
    logic [2:0] alu_bb, alu_sum;
    always_comb begin
        alu_bb  = alu_binv ? ~alu_b : alu_b;
        alu_sum = alu_a + alu_bb + {2'b00, alu_cin};
        alu_ovf = (alu_a[2] == alu_bb[2]) && (alu_sum[2] != alu_a[2]);
        case (alu_op)
            2'b00:   alu_res = alu_sum;
            2'b01:   alu_res = alu_a & alu_bb;
            2'b10:   alu_res = alu_a ^ alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    // Expected response from signed integer arithmetic on the request fields.
    function automatic void ref_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                                   input logic sub, output logic [2:0] res, output logic ovf);
        int sa, sb, r;
        sa  = (a > 3'd3) ? int'(a) - 8 : int'(a);
        sb  = (b > 3'd3) ? int'(b) - 8 : int'(b);
        r   = sub ? sa - sb : sa + sb;
        ovf = 1'b0;
        case (op)
            2'b00: begin res = r[2:0]; ovf = (r < -4) || (r > 3); end
            2'b01: begin res = sub ? (a & ~b) : (a & b); ovf = (r < -4) || (r > 3); end
            2'b10: res = a ^ b;
            default: res = a | b;
        endcase
    endfunction

    task automatic randomize_reqs();
        for (int i = 0; i < 2; i++) begin
            req_op[i]  = 2'($urandom_range(0, 3));
            req_a[i]   = 3'($urandom_range(0, 7));
            req_b[i]   = 3'($urandom_range(0, 7));
            req_sub[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Entry and exit point: #1 after a rising edge with the DUT in IDLE.
    task automatic run_txn(input logic [1:0] vmask, input int rdy_delay, input bit keep, output int gidx);
        logic [1:0] e_op, e_rdy;
        logic [2:0] e_a, e_b, e_res;
        logic       e_sub, e_ovf, e_x, e_inv, e_id, e_st_resp, e_st_idle;
        int         g;
        vld   = vmask;
        g     = (vmask == 2'b11) ? ptr_m : (vmask[1] ? 1 : 0);
        gidx  = g;
        e_id  = g[0];
        e_op  = req_op[g];
        e_a   = req_a[g];
        e_b   = req_b[g];
        e_sub = req_sub[g];
        ref_op(e_op, e_a, e_b, e_sub, e_res, e_ovf);
        e_x   = (e_op[1] == 1'b0);
        e_inv = e_x & e_sub;
        e_rdy = e_id ? 2'b10 : 2'b01;
        @(negedge clk);
        n_checks++;
        if ({r1_ready, r0_ready} !== e_rdy) begin
            n_fail++;
            $display("FAIL grant: ready=%b expected %b", {r1_ready, r0_ready}, e_rdy);
        end
        ptr_m = 1 - g;
        @(posedge clk); #1;
        if (!keep) vld = 2'b00;
        randomize_reqs();
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || {r1_ready, r0_ready} !== 2'b00 || alu_a !== e_a || alu_b !== e_b ||
                alu_op !== e_op || alu_x !== e_x || alu_binv !== e_inv || alu_cin !== e_inv) begin
                n_fail++;
                $display("FAIL inflight cyc%0d: vld=%b rdy=%b a=%0d b=%0d op=%0d x/binv/cin=%b%b%b expected vld=0 rdy=00 a=%0d b=%0d op=%0d x/binv/cin=%b%b%b",
                         k, rsp_valid, {r1_ready, r0_ready}, alu_a, alu_b, alu_op, alu_x, alu_binv, alu_cin,
                         e_a, e_b, e_op, e_x, e_inv, e_inv);
            end
        end
`ifdef ALU3_STICKY_OVF_EN
        if (e_ovf) sticky_m = 1'b1;
        e_st_resp = sticky_m;
        e_st_idle = sticky_m;
`else
        e_st_resp = e_ovf;
        e_st_idle = 1'b0;
`endif
        for (int k = 0; k <= rdy_delay; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_res !== e_res || rsp_id !== e_id || rsp_ovf !== e_ovf ||
                status_ovf !== e_st_resp || {r1_ready, r0_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL response cyc%0d: vld=%b res=%0d id=%b ovf=%b st=%b rdy=%b expected vld=1 res=%0d id=%b ovf=%b st=%b rdy=00",
                         k, rsp_valid, rsp_res, rsp_id, rsp_ovf, status_ovf, {r1_ready, r0_ready},
                         e_res, e_id, e_ovf, e_st_resp);
            end
            rsp_ready = (k == rdy_delay);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || status_ovf !== e_st_idle) begin
            n_fail++;
            $display("FAIL release: rsp_valid=%b status=%b expected 0 and %b", rsp_valid, status_ovf, e_st_idle);
        end
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        vld = 2'b11;
        randomize_reqs();
        #2 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            outs = {r0_ready, r1_ready, alu_a, alu_b, alu_op, alu_binv, alu_cin, alu_x,
                    rsp_valid, rsp_id, rsp_res, rsp_ovf, status_ovf};
            n_checks++;
            if (outs !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_outputs %0d: outputs=%h expected 00000", k, outs);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        vld = 2'b00;
        ptr_m = 0;
    endtask

    task automatic test_r0_add();
        int g;
        req_op[0] = 2'b00; req_a[0] = 3'd3; req_b[0] = 3'd2; req_sub[0] = 1'b0;
        run_txn(2'b01, 0, 1'b0, g);
    endtask

    task automatic test_r0_sub();
        int g;
        req_op[0] = 2'b00; req_a[0] = 3'd2; req_b[0] = 3'd3; req_sub[0] = 1'b1;
        run_txn(2'b01, 1, 1'b0, g);
    endtask

    task automatic test_overflow();
        int   g;
        logic e_st;
        req_op[0] = 2'b00; req_a[0] = 3'd3; req_b[0] = 3'd1; req_sub[0] = 1'b0;
        run_txn(2'b01, 0, 1'b0, g);
`ifdef ALU3_STICKY_OVF_EN
        e_st = sticky_m;
`else
        e_st = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (status_ovf !== e_st) begin
                n_fail++;
                $display("FAIL status_hold %0d: status=%b expected %b", k, status_ovf, e_st);
            end
        end
        @(posedge clk); #1;
`ifdef ALU3_STICKY_OVF_EN
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        sticky_m = 1'b0;
        n_checks++;
        if (status_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL status_clear: status=%b expected 0", status_ovf);
        end
`endif
    endtask

    task automatic test_backpressure();
        int g;
        randomize_reqs();
        run_txn(2'b11, 10, 1'b1, g);
    endtask

    task automatic test_round_robin();
        int g;
        run_txn(2'b10, 0, 1'b0, g);
        for (int n = 0; n < 4; n++) begin
            run_txn(2'b11, int'($urandom_range(0, 2)), 1'b1, g);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        randomize_reqs();
        vld = 2'b01;
        @(negedge clk);
        n_checks++;
        if ({r1_ready, r0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_grant: ready=%b expected 01", {r1_ready, r0_ready});
        end
        @(posedge clk); #1;
        vld = 2'b11;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready, alu_a, alu_b, alu_op, alu_binv, alu_cin, alu_x,
             rsp_valid, rsp_id, rsp_res, rsp_ovf, status_ovf} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: a=%0d b=%0d op=%0d x=%b rsp_valid=%b expected all 0",
                     alu_a, alu_b, alu_op, alu_x, rsp_valid);
        end
        ptr_m = 0;
`ifdef ALU3_STICKY_OVF_EN
        sticky_m = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || {r1_ready, r0_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_no_rsp %0d: rsp_valid=%b ready=%b expected 0 and 00",
                         k, rsp_valid, {r1_ready, r0_ready});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(2'b11, 0, 1'b0, g);
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g);
        end
        vld = 2'b00;
    endtask

    initial begin
        test_reset();
        test_r0_add();
        test_r0_sub();
        test_overflow();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu3_arb_ctrl.md
ALU3_ARB_CTRL -- requirements
Module: alu3_arb_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles the ALU operands are held before the result is sampled (legal 1..15).
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 R0_VALID, R1_VALID  in  1 each  requester n has an operation pending.
REQ-005 R0_READY, R1_READY  out  1 each  operation of requester n accepted this cycle.
REQ-006 R0_OP, R1_OP  in  2 each  ALU op code {OP1,OP0}.
REQ-007 R0_A, R0_B, R1_A, R1_B  in  3 each  operands.
REQ-008 R0_SUB, R1_SUB  in  1 each  subtract request (arithmetic ops only).
REQ-009 ALU_A, ALU_B  out  3 each  operands driven to the ALU.
REQ-010 ALU_OP  out  2  ALU op code; ALU_BINV, ALU_CIN, ALU_X  out  1 each  B invert, carry-in, overflow enable.
REQ-011 ALU_RES  in  3  ALU result bits; ALU_OVF  in  1  ALU overflow bit.
REQ-012 RSP_VALID  out  1; RSP_READY  in  1; RSP_ID  out  1 (requester index); RSP_RES  out  3; RSP_OVF  out  1.
REQ-013 STATUS_OVF  out  1; OVF_CLR  in  1 (present only per REQ-030).

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CAPTURE, RESP.
REQ-015 IDLE: if any R*_VALID, grant per REQ-016, pulse that R*_READY for exactly one cycle, latch op/operands, go SETTLE; else stay.
REQ-016 Arbitration SHALL be round-robin: pointer initial 0; both valid -> grant pointer; one valid -> grant it; after each grant pointer = other index.
REQ-017 R*_READY SHALL be 0 in every state except the granting IDLE cycle.
REQ-018 ALU_A/B/OP SHALL be registered copies of the granted request, stable from SETTLE entry until CAPTURE exit.
REQ-019 ALU_BINV and ALU_CIN SHALL be 1 when SUB=1 and OP1=0, else 0; ALU_X SHALL be 1 when OP1=0, else 0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles (4-bit down-counter), then CAPTURE.
REQ-021 CAPTURE (one cycle) SHALL register ALU_RES to RSP_RES, ALU_OVF&ALU_X to RSP_OVF, grant index to RSP_ID, then go RESP.
REQ-022 RESP: RSP_VALID=1 with RSP_* stable until RSP_READY=1; on that cycle go IDLE, RSP_VALID 0 next cycle.
REQ-023 Request-to-RSP_VALID latency SHALL be SETTLE_CYC+2 cycles from the R*_READY cycle.
REQ-024 Requester valid deasserting during SETTLE/CAPTURE/RESP SHALL NOT affect the in-flight operation.
REQ-025 No new grant SHALL occur while RSP_VALID=1 (one operation in flight).

Reset
REQ-026 RST=1 SHALL immediately force: state IDLE, pointer 0, counter 0, all outputs 0 (READY, RSP_*, ALU_*, STATUS_OVF).
REQ-027 RST asserted mid-operation SHALL discard the operation with no response.
REQ-028 First grant possible on the first rising edge after RST deasserts.

Configuration
REQ-029 Macro ALU3_STICKY_OVF_EN selects the sticky overflow status feature.
REQ-030 With ALU3_STICKY_OVF_EN: STATUS_OVF sets when CAPTURE samples RSP_OVF=1, holds until OVF_CLR=1 (clear wins over same-cycle set); OVF_CLR port exists.
REQ-031 Without it: no OVF_CLR port; STATUS_OVF SHALL equal RSP_OVF&RSP_VALID.

Structure
REQ-032 Package alu3_ctrl_pkg SHALL hold the state enum, op-code constants (OP_ADD 2'b00, OP_AND, OP_XOR, etc.) and the SETTLE counter width.
REQ-033 Sub-module alu3_rr_arb2 SHALL implement the two-way round-robin arbiter (valid pair, advance strobe -> grant one-hot, index).
REQ-034 The ALU SHALL be instantiated outside this block; connections via ALU_* ports only.

Verification
REQ-035 R0 only: OP=00, A=3, B=2, SUB=0, model sum 5 -> R0_READY 1 cycle, RSP_VALID at +4 cycles (SETTLE_CYC=2), RSP_RES=5, RSP_ID=0.
REQ-036 R0 SUB with A=2, B=3 -> ALU_BINV=1, ALU_CIN=1, ALU_X=1 during SETTLE; RSP_RES=7 (3-bit wrap).
REQ-037 Both valid continuously, 4 ops -> grant order 0,1,0,1; no READY during RESP.
REQ-038 Overflow: A=3, B=1 ADD, model ALU_OVF=1 -> RSP_OVF=1; with macro STATUS_OVF stays 1 until OVF_CLR pulse, then 0.
REQ-039 RSP_READY held 0 for 10 cycles -> RSP_* stable, no new grant; READY=1 -> IDLE next cycle.
REQ-040 RST asserted in SETTLE -> all outputs 0 at once, no response, next grant goes to R0.
